// File: rtl/sd_spi_responder.sv
// sd_spi_responder: behavioural SD-card model seen from the SPI side.
// Accepts 6-byte SD commands on a mode-0 SPI link and answers CMD0, CMD8,
// CMD55, ACMD41 and CMD17 (512-byte single block read of a counting pattern).
// Every flop runs on CLK_100MHZ. The host sd_clk is only sampled, never used
// as a clock.
//
// Ports:
//   CLK_100MHZ  in   system clock
//   RESET       in   asynchronous, active-high reset
//   sd_clk      in   host SPI clock (mode 0, asynchronous, <= 12.5 MHz)
//   sd_cs       in   host chip select, active-low
//   sd_mosi     in   host -> card serial data
//   sd_miso     out  card -> host serial data
//   idle        out  card idle flag (R1 bit 0)
//   cmd_count   out  number of accepted commands, wraps at 256
//
// Build option: define SD_RESP_CRC16_EN to send a real CRC16-CCITT after the
// data block. Without it the two CRC bytes are 0xFF and no CRC logic exists.
`timescale 1ns/1ps

module sd_spi_responder #(
    parameter int ACMD41_BUSY_COUNT = 2,
    parameter int NCR_BYTES         = 1,
    parameter int NAC_BYTES         = 2
) (
    input  logic       CLK_100MHZ,
    input  logic       RESET,
    input  logic       sd_clk,
    input  logic       sd_cs,
    input  logic       sd_mosi,
    output logic       sd_miso,
    output logic       idle,
    output logic [7:0] cmd_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_NCR, S_RESP, S_NAC, S_TOKEN, S_DATA, S_CRC
    } state_t;

    // Synchronizer bit order: {sd_clk, sd_cs, sd_mosi}; chip select resets deasserted
    localparam logic [2:0] SYNC_RST = 3'b010;

    logic [2:0]  meta_reg, sync_reg;
    logic        sclk_prev_reg;
    state_t      state_reg;
    logic [2:0]  bit_cnt_reg;
    logic [6:0]  rx_shift_reg;
    logic [7:0]  tx_shift_reg;
    logic [7:0]  cnt_reg;
    logic [8:0]  data_idx_reg;
    logic [5:0]  cmd_reg;
    logic [7:0]  arg_lo_reg;
    logic [31:0] resp_reg;
    logic [2:0]  resp_len_reg;
    logic        to_nac_reg;
    logic        app_reg;
    logic [7:0]  acmd_cnt_reg;
    logic        idle_reg;
    logic [7:0]  cmd_count_reg;
    logic        miso_reg;
`ifdef SD_RESP_CRC16_EN
    logic [15:0] crc_reg;

    // CRC16-CCITT (poly 0x1021), one whole byte per call, MSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {d, 8'h00};
        for (int k = 0; k < 8; k++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
    logic [7:0] rx_byte;
    logic [7:0] data_next;

    assign sclk_s    = sync_reg[2];
    assign cs_s      = sync_reg[1];
    assign mosi_s    = sync_reg[0];
    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign rx_byte   = {rx_shift_reg, mosi_s};
    assign data_next = arg_lo_reg + data_idx_reg[7:0] + 8'd1;

    assign sd_miso   = miso_reg;
    assign idle      = idle_reg;
    assign cmd_count = cmd_count_reg;

    // Response decode for the command held in cmd_reg; applied when the last
    // NCR filler byte completes so the R1 byte is ready for the next falling edge.
    logic [7:0]  r1_c;
    logic [31:0] rest_c;
    logic [2:0]  len_c;
    logic        to_nac_c, idle_c;
    logic [7:0]  acmd_c;

    always_comb begin
        r1_c     = {5'b0, 1'b1, 1'b0, idle_reg};
        rest_c   = 32'hFFFF_FFFF;
        len_c    = 3'd1;
        to_nac_c = 1'b0;
        idle_c   = idle_reg;
        acmd_c   = acmd_cnt_reg;
        case (cmd_reg)
            6'd0: begin
                r1_c   = 8'h01;
                idle_c = 1'b1;
                acmd_c = 8'd0;
            end
            6'd8: begin
                r1_c   = {7'b0, idle_reg};
                len_c  = 3'd5;
                rest_c = {8'h00, 8'h00, 8'h01, arg_lo_reg};
            end
            6'd55: r1_c = {7'b0, idle_reg};
            6'd41: begin
                if (app_reg) begin
                    if (int'(acmd_cnt_reg) < ACMD41_BUSY_COUNT) begin
                        r1_c   = 8'h01;
                        acmd_c = acmd_cnt_reg + 8'd1;
                    end else begin
                        r1_c   = 8'h00;
                        idle_c = 1'b0;
                    end
                end
            end
            6'd17: begin
                if (!idle_reg) begin
                    r1_c     = 8'h00;
                    to_nac_c = 1'b1;
                end else begin
                    r1_c = 8'h05;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_100MHZ or posedge RESET) begin
        if (RESET) begin
            meta_reg      <= SYNC_RST;
            sync_reg      <= SYNC_RST;
            sclk_prev_reg <= 1'b0;
            state_reg     <= S_IDLE;
            bit_cnt_reg   <= 3'd0;
            rx_shift_reg  <= 7'd0;
            tx_shift_reg  <= 8'd0;
            cnt_reg       <= 8'd0;
            data_idx_reg  <= 9'd0;
            cmd_reg       <= 6'd0;
            arg_lo_reg    <= 8'd0;
            resp_reg      <= 32'd0;
            resp_len_reg  <= 3'd0;
            to_nac_reg    <= 1'b0;
            app_reg       <= 1'b0;
            acmd_cnt_reg  <= 8'd0;
            idle_reg      <= 1'b1;
            cmd_count_reg <= 8'd0;
            miso_reg      <= 1'b1;
`ifdef SD_RESP_CRC16_EN
            crc_reg       <= 16'd0;
`endif
        end else begin
            meta_reg      <= {sd_clk, sd_cs, sd_mosi};
            sync_reg      <= meta_reg;
            sclk_prev_reg <= sclk_s;

            // Chip select wins over any clock edge seen in the same cycle
            if (cs_s) begin
                state_reg    <= S_IDLE;
                bit_cnt_reg  <= 3'd0;
                miso_reg     <= 1'b1;
                tx_shift_reg <= 8'hFF;
            end else if (sclk_rise) begin
                rx_shift_reg <= rx_byte[6:0];
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    // A byte just completed: pick the byte to shift out next
                    tx_shift_reg <= 8'hFF;
                    case (state_reg)
                        S_IDLE: begin
                            if (rx_byte[7:6] == 2'b01) begin
                                cmd_reg   <= rx_byte[5:0];
                                cnt_reg   <= 8'd0;
                                state_reg <= S_CMD;
                            end
                        end
                        S_CMD: begin
                            // Argument bytes arrive MSB first; only the low byte is needed
                            if (cnt_reg == 8'd3) arg_lo_reg <= rx_byte;
                            if (cnt_reg == 8'd4) begin
                                cmd_count_reg <= cmd_count_reg + 8'd1;
                                cnt_reg       <= 8'd0;
                                state_reg     <= S_NCR;
                            end else begin
                                cnt_reg <= cnt_reg + 8'd1;
                            end
                        end
                        S_NCR: begin
                            if (cnt_reg == 8'(NCR_BYTES - 1)) begin
                                state_reg    <= S_RESP;
                                cnt_reg      <= 8'd0;
                                tx_shift_reg <= r1_c;
                                resp_reg     <= rest_c;
                                resp_len_reg <= len_c;
                                to_nac_reg   <= to_nac_c;
                                idle_reg     <= idle_c;
                                acmd_cnt_reg <= acmd_c;
                                app_reg      <= (cmd_reg == 6'd55);
                            end else begin
                                cnt_reg <= cnt_reg + 8'd1;
                            end
                        end
                        S_RESP: begin
                            if (cnt_reg[2:0] == resp_len_reg - 3'd1) begin
                                cnt_reg   <= 8'd0;
                                state_reg <= to_nac_reg ? S_NAC : S_IDLE;
                            end else begin
                                cnt_reg      <= cnt_reg + 8'd1;
                                tx_shift_reg <= resp_reg[31:24];
                                resp_reg     <= {resp_reg[23:0], 8'hFF};
                            end
                        end
                        S_NAC: begin
                            if (cnt_reg == 8'(NAC_BYTES - 1)) begin
                                state_reg    <= S_TOKEN;
                                tx_shift_reg <= 8'hFE;
                            end else begin
                                cnt_reg <= cnt_reg + 8'd1;
                            end
                        end
                        S_TOKEN: begin
                            state_reg    <= S_DATA;
                            data_idx_reg <= 9'd0;
                            tx_shift_reg <= arg_lo_reg;
`ifdef SD_RESP_CRC16_EN
                            crc_reg      <= crc16_byte(16'd0, arg_lo_reg);
`endif
                        end
                        S_DATA: begin
                            if (data_idx_reg == 9'd511) begin
                                state_reg <= S_CRC;
                                cnt_reg   <= 8'd0;
`ifdef SD_RESP_CRC16_EN
                                tx_shift_reg <= crc_reg[15:8];
`endif
                            end else begin
                                data_idx_reg <= data_idx_reg + 9'd1;
                                tx_shift_reg <= data_next;
`ifdef SD_RESP_CRC16_EN
                                crc_reg      <= crc16_byte(crc_reg, data_next);
`endif
                            end
                        end
                        S_CRC: begin
                            if (cnt_reg == 8'd0) begin
                                cnt_reg <= 8'd1;
`ifdef SD_RESP_CRC16_EN
                                tx_shift_reg <= crc_reg[7:0];
`endif
                            end else begin
                                state_reg <= S_IDLE;
                            end
                        end
                        default: state_reg <= S_IDLE;
                    endcase
                end
            end else if (sclk_fall) begin
                // Mode 0: the card changes sd_miso on the falling edge
                miso_reg     <= (state_reg == S_IDLE) ? 1'b1 : tx_shift_reg[7];
                tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Testbench for sd_spi_responder: a 10 MHz SPI host drives commands and a
// behavioural SD-card model predicts every returned byte and status output.
`timescale 1ns/1ps

module tb_sd_spi_responder;

    localparam int BUSY = 2;
    localparam int NCR  = 1;
    localparam int NAC  = 2;

    logic       CLK_100MHZ = 1'b0;
    logic       RESET      = 1'b1;
    logic       sd_clk     = 1'b0;
    logic       sd_cs      = 1'b1;
    logic       sd_mosi    = 1'b1;
    logic       sd_miso;
    logic       idle;
    logic [7:0] cmd_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference card state
    logic       m_idle  = 1'b1;
    logic       m_app   = 1'b0;
    int         m_acmd  = 0;
    logic [7:0] m_count = 8'd0;
    logic [7:0] exp_q[$];

    sd_spi_responder #(
        .ACMD41_BUSY_COUNT(BUSY),
        .NCR_BYTES(NCR),
        .NAC_BYTES(NAC)
    ) dut (
        .CLK_100MHZ(CLK_100MHZ),
        .RESET(RESET),
        .sd_clk(sd_clk),
        .sd_cs(sd_cs),
        .sd_mosi(sd_mosi),
        .sd_miso(sd_miso),
        .idle(idle),
        .cmd_count(cmd_count)
    );

    always #5 CLK_100MHZ = ~CLK_100MHZ;

    // Bit-serial CRC16-CCITT over the 512-byte counting pattern
    function automatic logic [15:0] ref_crc(input logic [7:0] first);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'h0000;
        for (int i = 0; i < 512; i++) begin
            b = first + 8'(i);
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ b[j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // One SPI mode-0 byte at 10 MHz; sd_clk edges fall on CLK negedges
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sd_mosi = tx[i];
            #50;
            sd_clk = 1'b1;
            rx[i]  = sd_miso;
            #50;
            sd_clk = 1'b0;
        end
    endtask

    // Predict the full reply to a command and update the card model
    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [7:0] r1;
        logic [7:0] lo;
        bit         to_data;
`ifdef SD_RESP_CRC16_EN
        logic [15:0] c;
`endif
        lo      = arg[7:0];
        to_data = 1'b0;
        exp_q.delete();
        m_count = m_count + 8'd1;
        r1 = m_idle ? 8'h05 : 8'h04;
        if (idx == 6'd0) begin
            r1 = 8'h01; m_idle = 1'b1; m_acmd = 0;
        end else if (idx == 6'd8 || idx == 6'd55) begin
            r1 = m_idle ? 8'h01 : 8'h00;
        end else if (idx == 6'd41 && m_app) begin
            if (m_acmd < BUSY) begin
                r1 = 8'h01; m_acmd++;
            end else begin
                r1 = 8'h00; m_idle = 1'b0;
            end
        end else if (idx == 6'd17) begin
            if (m_idle) r1 = 8'h05;
            else begin
                r1 = 8'h00; to_data = 1'b1;
            end
        end
        m_app = (idx == 6'd55);
        repeat (NCR) exp_q.push_back(8'hFF);
        exp_q.push_back(r1);
        if (idx == 6'd8) begin
            exp_q.push_back(8'h00); exp_q.push_back(8'h00);
            exp_q.push_back(8'h01); exp_q.push_back(lo);
        end
        if (to_data) begin
            repeat (NAC) exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFE);
            for (int i = 0; i < 512; i++) exp_q.push_back(lo + 8'(i));
`ifdef SD_RESP_CRC16_EN
            c = ref_crc(lo);
            exp_q.push_back(c[15:8]);
            exp_q.push_back(c[7:0]);
`else
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFF);
`endif
        end
    endtask

    // Send one command, then read 'limit' reply bytes (all when limit < 0)
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input int limit, input string name);
        logic [7:0] bytes[6];
        logic [7:0] r;
        int n, bad;
        bytes[0] = {2'b01, idx};
        bytes[1] = arg[31:24];
        bytes[2] = arg[23:16];
        bytes[3] = arg[15:8];
        bytes[4] = arg[7:0];
        bytes[5] = (idx == 6'd0) ? 8'h95 : ((idx == 6'd8) ? 8'h87 : 8'h01);
        model_cmd(idx, arg);
        bad = n_fail;
        for (int i = 0; i < 6; i++) begin
            spi_byte(bytes[i], r);
            n_checks++;
            if (r !== 8'hFF) begin
                n_fail++;
                $display("FAIL %s cmd_phase byte %0d: got %02h, expected ff", name, i, r);
            end
        end
        n = (limit < 0) ? exp_q.size() : limit;
        for (int i = 0; i < n; i++) begin
            spi_byte(8'hFF, r);
            n_checks++;
            if (r !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s reply byte %0d: got %02h, expected %02h", name, i, r, exp_q[i]);
            end
        end
        #20;
        n_checks++;
        if (cmd_count !== m_count) begin
            n_fail++;
            $display("FAIL %s cmd_count: got %0d, expected %0d", name, cmd_count, m_count);
        end
        n_checks++;
        if (idle !== m_idle) begin
            n_fail++;
            $display("FAIL %s idle: got %0b, expected %0b", name, idle, m_idle);
        end
        $display("txn %s: cmd%0d arg=%08h, %0d reply bytes read, %0d errors",
                 name, idx, arg, n, n_fail - bad);
    endtask

    task automatic test_reset();
        #50;
        n_checks++;
        if (idle !== 1'b1 || cmd_count !== 8'd0 || sd_miso !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: idle=%0b cmd_count=%0d miso=%0b, expected 1 0 1", idle, cmd_count, sd_miso);
        end
        #50;
        RESET = 1'b0;
        #100;
        n_checks++;
        if (idle !== 1'b1 || cmd_count !== 8'd0 || sd_miso !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: idle=%0b cmd_count=%0d miso=%0b, expected 1 0 1", idle, cmd_count, sd_miso);
        end
        sd_cs = 1'b0;
        #100;
    endtask

    task automatic test_cmd0();
        run_cmd(6'd0, 32'h0, -1, "cmd0");
    endtask

    task automatic test_cmd8();
        run_cmd(6'd8, 32'h0000_01AA, -1, "cmd8");
        run_cmd(6'd8, $urandom, -1, "cmd8_rand");
    endtask

    task automatic test_ignore();
        logic [7:0] j, r;
        logic [5:0] unk[4];
        unk = '{6'd1, 6'd13, 6'd58, 6'd59};
        for (int k = 0; k < 4; k++) begin
            j = 8'($urandom_range(0, 255));
            if (j[7:6] == 2'b01) j[6] = 1'b0;
            spi_byte(j, r);
            n_checks++;
            if (r !== 8'hFF) begin
                n_fail++;
                $display("FAIL junk byte %02h: got %02h, expected ff", j, r);
            end
        end
        #20;
        n_checks++;
        if (cmd_count !== m_count) begin
            n_fail++;
            $display("FAIL junk cmd_count: got %0d, expected %0d", cmd_count, m_count);
        end
        run_cmd(unk[$urandom_range(0, 3)], $urandom, -1, "unknown");
        run_cmd(6'd41, 32'h4000_0000, -1, "bare_cmd41");
        run_cmd(6'd17, 32'h0, -1, "cmd17_idle");
    endtask

    task automatic test_acmd41();
        for (int k = 0; k < 3; k++) begin
            run_cmd(6'd55, 32'h0, -1, "cmd55");
            run_cmd(6'd41, 32'h4000_0000, -1, "acmd41");
        end
        n_checks++;
        if (idle !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_acmd41: got %0b, expected 0", idle);
        end
    endtask

    task automatic test_cmd17();
        run_cmd(6'd17, 32'h0000_0010, -1, "cmd17");
    endtask

    task automatic test_reset_mid();
        run_cmd(6'd17, $urandom, NCR + 1 + NAC + 1 + 20, "cmd17_partial");
        RESET = 1'b1;
        #50;
        n_checks++;
        if (idle !== 1'b1 || cmd_count !== 8'd0 || sd_miso !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: idle=%0b cmd_count=%0d miso=%0b, expected 1 0 1", idle, cmd_count, sd_miso);
        end
        RESET   = 1'b0;
        m_idle  = 1'b1;
        m_app   = 1'b0;
        m_acmd  = 0;
        m_count = 8'd0;
        #100;
        sd_cs = 1'b1;
        #200;
        sd_cs = 1'b0;
        #100;
        run_cmd(6'd17, 32'h0, -1, "cmd17_after_reset");
    endtask

    task automatic test_cs_abort();
        for (int k = 0; k < 3; k++) begin
            run_cmd(6'd55, 32'h0, -1, "cmd55");
            run_cmd(6'd41, 32'h4000_0000, -1, "acmd41");
        end
        run_cmd(6'd17, $urandom, NCR + 1 + NAC + 1 + 100, "cmd17_abort");
        #30;
        sd_cs = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #100;
            n_checks++;
            if (sd_miso !== 1'b1) begin
                n_fail++;
                $display("FAIL cs_high_miso sample %0d: got %0b, expected 1", k, sd_miso);
            end
        end
        sd_cs = 1'b0;
        #100;
        run_cmd(6'd0, 32'h0, -1, "cmd0_after_abort");
    endtask

    task automatic test_back_to_back();
        logic [5:0] pool[6];
        pool = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd13, 6'd58};
        for (int k = 0; k < 4; k++) begin
            run_cmd(pool[$urandom_range(0, 5)], $urandom, -1, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_ignore();
        test_acmd41();
        test_cmd17();
        test_reset_mid();
        test_cs_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
